regfile: RTL
============

Name: regfile

Overview:
- Integer register file of the 5-stage RISC-V core: 32 x 32-bit architectural registers, x0 hardwired to zero.
- Consumer end of the write-back interface. Takes the registered write enable, address and data from the MEM/WB pipeline register and commits them on the clock edge.
- Serves two read ports to the ID stage in the same cycle.
- A write-to-read bypass lets ID see a value being written back in the same cycle, with no extra stall.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of registers; equals 2**ADDR_WIDTH.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write-back enable, from the MEM/WB register.
- waddr  input  ADDR_WIDTH  write-back destination register.
- wdata  input  DATA_WIDTH  write-back data.
- re1  input  1  read-port-1 enable, from ID.
- raddr1  input  ADDR_WIDTH  read-port-1 address.
- rdata1  output  DATA_WIDTH  read-port-1 data (combinational).
- re2  input  1  read-port-2 enable, from ID.
- raddr2  input  ADDR_WIDTH  read-port-2 address.
- rdata2  output  DATA_WIDTH  read-port-2 data (combinational).

Behaviour:
- Reset: synchronous, active-high. On any posedge with rst=1, all registers x0..x31 are cleared to 0, and any write presented that cycle is discarded.
- While rst=1, rdata1 and rdata2 are driven to 0, combinationally, regardless of other inputs.
- Reset mid-operation: the register contents are lost. After rst deasserts, every register reads 0 until it is written.
- Write: at posedge, when rst=0, we=1 and waddr!=0, the register at waddr takes wdata. The new value is architecturally visible from the next cycle.
- Writes with waddr=0 are silently dropped; x0 is never stored.
- Writes with we=0 change nothing, whatever waddr and wdata carry. The MEM/WB register drives we=0, waddr=0, wdata=0 on a bubble or stall.
- Read ports are combinational, with zero-cycle latency. Priority per port n, highest first:
  1. rst=1 -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0.
  4. we=1 and waddr==raddr_n -> wdata (bypass, same cycle).
  5. Otherwise -> the stored register value.
- Both ports are independent. Both may read the same address, and both may hit the bypass at once.
- The bypass never applies to x0. A write to x0 with we=1 must not leak wdata onto a read of x0.
- Write and read of the same register in the same cycle: the read returns the new data through the bypass, and the store also commits at the edge. There is no conflict.
- No back-pressure and no handshake. A write is accepted every cycle it is presented, with a sustained throughput of 1 write per cycle.
- Width: wdata is stored unmodified, with no sign or zero extension. Addresses are used modulo 2**ADDR_WIDTH.
- Storage and read muxing only. There is no hazard detection; forwarding from EX and MEM stays in ID.

Test Plan:
- Reset clear: preload x5 = 0xDEADBEEF, pulse rst for 1 cycle, then read x5 on port 1 with re1=1 -> rdata1 = 0x00000000. While rst=1, both rdata outputs = 0.
- Basic write/read: we=1, waddr=3, wdata=0x12345678 at edge N; at N+1, with we=0, read port 2 addr 3 -> rdata2 = 0x12345678.
- Bypass: x7 = 0x11111111 stored; in the same cycle present we=1, waddr=7, wdata=0xA5A5A5A5 and raddr1=raddr2=7 -> both ports read 0xA5A5A5A5 before the edge. The next cycle, with we=0, both still read 0xA5A5A5A5.
- x0 protection: we=1, waddr=0, wdata=0xFFFFFFFF with raddr1=0 -> rdata1 = 0 in that cycle and every later cycle.
- Read enable gating: x9 = 0x0000BEEF; re1=0, raddr1=9 -> rdata1 = 0. re2=1, raddr2=9 -> rdata2 = 0x0000BEEF.
- Write during reset and back-to-back writes: rst=1 with we=1, waddr=4, wdata=0x55 -> after release x4 reads 0. Then write x4 = 1, 2, 3 on three consecutive edges, reading x4 each cycle -> bypass shows 1, 2, 3 in order, and the stored value is 3 afterwards.

Source files
------------

// File: rtl/regfile.sv
// Integer register file for the 5-stage RISC-V core.
// 32 x DATA_WIDTH architectural registers, x0 hardwired to zero.
// Two combinational read ports for ID and one write-back port from MEM/WB.
// A same-cycle bypass makes the value being written back visible to ID at once.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    // Entry 0 is cleared by reset and never written, so it always holds zero.
    logic [DATA_WIDTH-1:0] r_regs [0:NUM_REGS-1];

    // A write to x0 is dropped here. Every read path also returns zero for x0
    // before it looks at the bypass, so a write to x0 cannot leak wdata.
    logic w_wr_valid;
    assign w_wr_valid = we && (waddr != '0);

    // Commit write-back at the clock edge. Reset clears every register.
    always_ff @(posedge clk) begin
        // NOTE: this storage has a reset on purpose. After a reset every
        // register must read 0 until it is written, so the contents are
        // cleared here instead of being left in the state they held.
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: use non-blocking (<=) for state in always_ff. Then every
                // register updates together at the edge, whatever the order of
                // the statements.
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Read port 1: reset, enable, x0, bypass, stored value (highest priority first).
    always_comb begin
        // NOTE: assign a default first so every path drives rdata1. A path
        // that left it unassigned would infer a latch.
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_regs[raddr1];
        end
    end

    // Read port 2: same priority as port 1, fully independent of it.
    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_regs[raddr2];
        end
    end

endmodule
